// File: rtl/logcap_cmd_initiator_pkg.sv
// Shared opcodes, status bit positions and FSM encoding for the capture-core command initiator.
package logcap_cmd_pkg;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_START    = 8'h01;
    localparam logic [7:0] OP_ABORT    = 8'h02;
    localparam logic [7:0] OP_TRIG_CFG = 8'h03;
    localparam logic [7:0] OP_BUF_CFG  = 8'h04;
    localparam logic [7:0] OP_RD_DATA  = 8'h05;
    localparam logic [7:0] OP_RD_SIZE  = 8'h06;
    localparam logic [7:0] OP_ACK      = 8'h08;
    localparam logic [7:0] OP_RESET    = 8'h09;
    localparam logic [7:0] OP_RD_TRIG  = 8'h10;

    localparam int unsigned ST_ACK  = 3;
    localparam int unsigned ST_POST = 2;
    localparam int unsigned ST_PRE  = 1;
    localparam int unsigned ST_IDLE = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECLR,
        S_PREWAIT,
        S_ISSUE,
        S_WAITACK,
        S_CLEAR,
        S_WAITCLR,
        S_RESP
    } state_e;

    function automatic logic is_wait_state(state_e s);
        return (s == S_PREWAIT) || (s == S_WAITACK) || (s == S_WAITCLR);
    endfunction

    function automatic logic is_strobe_state(state_e s);
        return (s == S_PRECLR) || (s == S_ISSUE) || (s == S_CLEAR);
    endfunction

endpackage

// File: rtl/logcap_cmd_initiator_if.sv
// Host-side request/response channel between the transport decoder and the command initiator.
interface logcap_cmd_initiator_if;

    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_opcode;
    logic [63:0] req_payload;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [7:0]  rsp_status;
    logic        rsp_timeout;

    modport master (
        output req_valid, req_opcode, req_payload, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_status, rsp_timeout
    );

    modport slave (
        input  req_valid, req_opcode, req_payload, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_status, rsp_timeout
    );

endinterface

// File: rtl/logcap_cmd_initiator_wait_timer.sv
// Cycle counter shared by the three wait states; flags the last permitted cycle of a wait.
module logcap_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TO_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    // Saturates at LAST so a held enable can never wrap back to a fresh budget.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/logcap_cmd_initiator.sv
// HUB-side initiator: issues one host command to the capture core, waits for its ack, returns the response.
module logcap_cmd_initiator
    import logcap_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TO_W           = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    logcap_cmd_initiator_if.slave        host,
    output logic [7:0]                   regIn0,
    output logic [7:0]                   regIn1,
    output logic [7:0]                   regIn2,
    output logic [7:0]                   regIn3,
    output logic [7:0]                   regIn4,
    output logic [7:0]                   regIn5,
    output logic [7:0]                   regIn6,
    output logic [7:0]                   regIn7,
    output logic [7:0]                   command,
    output logic                         command_strobe,
    input  logic [7:0]                   status,
    input  logic [7:0]                   regOut0,
    input  logic [7:0]                   regOut1,
    input  logic [7:0]                   regOut2,
    input  logic [7:0]                   regOut3,
    input  logic [7:0]                   regOut4,
    input  logic [7:0]                   regOut5,
    input  logic [7:0]                   regOut6,
    input  logic [7:0]                   regOut7,
    output logic                         busy
);

    state_e      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [63:0] reg_in_q, reg_in_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic [7:0]  rsp_status_q, rsp_status_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [7:0]  command_q, command_d;
    logic        strobe_q, strobe_d;
    logic        req_ready_q, req_ready_d;
    logic        busy_q, busy_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        expired;
    logic        ack;
    logic [63:0] reg_out;

    assign ack     = status[ST_ACK];
    assign reg_out = {regOut7, regOut6, regOut5, regOut4, regOut3, regOut2, regOut1, regOut0};

    logcap_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (!is_wait_state(state_q)),
        .enable_i (is_wait_state(state_q)),
        .expire_o (expired)
    );

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        reg_in_d      = reg_in_q;
        rsp_data_d    = rsp_data_q;
        rsp_status_d  = rsp_status_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (host.req_valid && req_ready_q) begin
                    opcode_d      = host.req_opcode;
                    reg_in_d      = host.req_payload;
                    rsp_data_d    = '0;
                    rsp_status_d  = '0;
                    rsp_timeout_d = 1'b0;
                    state_d       = ack ? S_PRECLR : S_ISSUE;
                end
            end
            S_PRECLR: state_d = S_PREWAIT;
            S_PREWAIT: begin
                if (!ack) begin
                    state_d = S_ISSUE;
                end else if (expired) begin
                    rsp_timeout_d = 1'b1;
                    rsp_status_d  = status;
                    state_d       = S_RESP;
                end
            end
            S_ISSUE: state_d = (opcode_q == OP_NOP) ? S_RESP : S_WAITACK;
            S_WAITACK: begin
                // regOut is valid on the same edge the ack rises, so capture here.
                if (ack) begin
                    rsp_data_d   = reg_out;
                    rsp_status_d = status;
                    state_d      = S_CLEAR;
                end else if (expired) begin
                    rsp_timeout_d = 1'b1;
                    rsp_data_d    = '0;
                    rsp_status_d  = status;
                    state_d       = S_RESP;
                end
            end
            S_CLEAR: state_d = S_WAITCLR;
            S_WAITCLR: begin
                if (!ack) begin
                    state_d = S_RESP;
                end else if (expired) begin
                    rsp_timeout_d = 1'b1;
                    rsp_data_d    = '0;
                    rsp_status_d  = status;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                if (host.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        strobe_d    = is_strobe_state(state_d);
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        command_d   = OP_NOP;
        if (state_d == S_ISSUE) begin
            command_d = opcode_d;
        end else if ((state_d == S_PRECLR) || (state_d == S_CLEAR)) begin
            command_d = OP_ACK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            opcode_q      <= OP_NOP;
            reg_in_q      <= '0;
            rsp_data_q    <= '0;
            rsp_status_q  <= '0;
            rsp_timeout_q <= 1'b0;
            command_q     <= OP_NOP;
            strobe_q      <= 1'b0;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            reg_in_q      <= reg_in_d;
            rsp_data_q    <= rsp_data_d;
            rsp_status_q  <= rsp_status_d;
            rsp_timeout_q <= rsp_timeout_d;
            command_q     <= command_d;
            strobe_q      <= strobe_d;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            rsp_valid_q   <= rsp_valid_d;
        end
    end

    assign host.req_ready   = req_ready_q;
    assign host.rsp_valid   = rsp_valid_q;
    assign host.rsp_data    = rsp_data_q;
    assign host.rsp_status  = rsp_status_q;
    assign host.rsp_timeout = rsp_timeout_q;

    assign regIn0 = reg_in_q[7:0];
    assign regIn1 = reg_in_q[15:8];
    assign regIn2 = reg_in_q[23:16];
    assign regIn3 = reg_in_q[31:24];
    assign regIn4 = reg_in_q[39:32];
    assign regIn5 = reg_in_q[47:40];
    assign regIn6 = reg_in_q[55:48];
    assign regIn7 = reg_in_q[63:56];

    assign command        = command_q;
    assign command_strobe = strobe_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_logcap_cmd_initiator.sv
// Directed bench: a behavioural capture-core responder plus a command/response scoreboard checked every cycle.
`timescale 1ns/1ps
module tb_logcap_cmd_initiator;
    import logcap_cmd_pkg::*;

    localparam int unsigned TO_CYC = 16;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] ri0, ri1, ri2, ri3, ri4, ri5, ri6, ri7;
    logic [7:0] command;
    logic command_strobe;
    logic [7:0] status;
    logic [63:0] ro_all;
    logic busy;
    logic [63:0] ri_all;

    logcap_cmd_initiator_if host_if ();

    logcap_cmd_initiator #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(16)) dut (
        .clk(clk), .reset(reset), .host(host_if),
        .regIn0(ri0), .regIn1(ri1), .regIn2(ri2), .regIn3(ri3),
        .regIn4(ri4), .regIn5(ri5), .regIn6(ri6), .regIn7(ri7),
        .command(command), .command_strobe(command_strobe), .status(status),
        .regOut0(ro_all[7:0]), .regOut1(ro_all[15:8]), .regOut2(ro_all[23:16]), .regOut3(ro_all[31:24]),
        .regOut4(ro_all[39:32]), .regOut5(ro_all[47:40]), .regOut6(ro_all[55:48]), .regOut7(ro_all[63:56]),
        .busy(busy)
    );

    assign ri_all = {ri7, ri6, ri5, ri4, ri3, ri2, ri1, ri0};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard state
    logic [7:0]  exp_cmd_q[$];
    logic [63:0] exp_payload = '0;
    logic [63:0] exp_data = '0;
    logic [7:0]  exp_status = '0;
    bit          exp_status_care = 0;
    bit          exp_timeout = 0;
    bit          exp_rsp_allowed = 0;
    bit          chk_en = 0;
    bit          rsp_prev = 0;
    int          rsp_first_cyc = 0;
    int          first_strobe_cyc = -1;
    int          valid_run = 0;

    // Responder configuration / state
    bit          ack_bit = 0;
    logic [2:0]  flags = '0;
    int          ack_cnt = 0;
    int          clr_cnt = 0;
    int          ack_delay = 2;
    bit          never_ack = 0;
    bit          never_clr = 0;
    logic [63:0] resp_regs = '0;

    // Core model: acks an opcode ack_delay cycles after its strobe, drops ack one cycle after an ACK strobe.
    initial begin
        status = 8'h00;
        ro_all = '0;
        forever begin
            @(posedge clk);
            #2;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    ack_bit = 1;
                    ro_all  = resp_regs;
                end
            end
            if (clr_cnt > 0) begin
                clr_cnt--;
                if (clr_cnt == 0) ack_bit = 0;
            end
            if (command_strobe === 1'b1) begin
                if (command == OP_ACK) begin
                    if (!never_clr) clr_cnt = 1;
                end else if (command != OP_NOP && !never_ack) begin
                    ack_cnt = ack_delay;
                end
            end
            status = {4'h0, ack_bit, flags};
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (command_strobe !== 1'b1) begin
                chk("cmd_zero_without_strobe", command, OP_NOP);
            end else begin
                if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
                if (exp_cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got command %h expected no strobe (cycle %0d)", command, cyc);
                end else begin
                    logic [7:0] e;
                    e = exp_cmd_q.pop_front();
                    chk("strobe_cmd", command, e);
                    if (e != OP_ACK) chk("ack_low_at_issue", status[ST_ACK], 0);
                end
            end
            chk("req_ready_not_busy", host_if.req_ready, !busy);
            chk("regin_payload", ri_all, exp_payload);
            if (host_if.rsp_valid === 1'b1) begin
                if (!rsp_prev) begin
                    rsp_first_cyc = cyc;
                    valid_run = 0;
                end
                valid_run++;
                if (!exp_rsp_allowed) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    chk("rsp_data", host_if.rsp_data, exp_data);
                    chk("rsp_timeout", host_if.rsp_timeout, exp_timeout);
                    if (exp_status_care) chk("rsp_status", host_if.rsp_status, exp_status);
                    chk("req_ready_in_resp", host_if.req_ready, 0);
                end
            end
            rsp_prev = (host_if.rsp_valid === 1'b1);
        end
    end

    // Expected strobe sequence and response derived from the command protocol rules.
    task automatic plan(input logic [7:0] op, input bit stale, input bit acks,
                        input logic [63:0] regs, input logic [2:0] fl, input int dly);
        if (stale) exp_cmd_q.push_back(OP_ACK);
        exp_cmd_q.push_back(op);
        if (op != OP_NOP && acks) exp_cmd_q.push_back(OP_ACK);
        exp_data        = (op != OP_NOP && acks) ? regs : 64'h0;
        exp_timeout     = (op != OP_NOP) && !acks;
        exp_status      = {4'h0, acks, fl};
        exp_status_care = (op != OP_NOP);
        resp_regs       = regs;
        flags           = fl;
        ack_delay       = dly;
        never_ack       = !acks;
        first_strobe_cyc = -1;
    endtask

    int acc_cyc;
    int hs_cyc;
    logic [63:0] got_data;
    logic [7:0]  got_status;
    logic        got_timeout;

    task automatic send_req(input logic [7:0] op, input logic [63:0] payload);
        bit rdy;
        bit accepted = 0;
        host_if.req_valid   = 1'b1;
        host_if.req_opcode  = op;
        host_if.req_payload = payload;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            rdy = host_if.req_ready;
            acc_cyc = cyc;
            @(posedge clk);
            if (rdy) begin
                accepted = 1;
                break;
            end
        end
        #1;
        host_if.req_valid = 1'b0;
        chk("req_accepted", accepted, 1);
        exp_payload     = payload;
        exp_rsp_allowed = 1;
    endtask

    task automatic wait_rsp(input int bp);
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (host_if.rsp_valid === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk("rsp_seen", seen, 1);
        if (!seen) begin
            @(posedge clk);
            #1;
            return;
        end
        got_data    = host_if.rsp_data;
        got_status  = host_if.rsp_status;
        got_timeout = host_if.rsp_timeout;
        repeat (bp) @(negedge clk);
        host_if.rsp_ready = 1'b1;
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        host_if.rsp_ready = 1'b0;
        exp_rsp_allowed   = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        host_if.req_valid   = 1'b0;
        host_if.req_opcode  = '0;
        host_if.req_payload = '0;
        host_if.rsp_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", host_if.req_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", host_if.rsp_valid, 0);
        chk("reset_command", command, 8'h00);
        chk("reset_strobe", command_strobe, 0);
        chk("reset_regin", ri_all, 64'h0);
        chk("reset_rsp_timeout", host_if.rsp_timeout, 0);
        chk_en = 1;
        idle(1);

        // TRIG_CFG, ack two cycles after strobe
        plan(OP_TRIG_CFG, 0, 1, 64'h1122_3344_5566_7788, 3'b001, 2);
        send_req(OP_TRIG_CFG, 64'h0000_00FF_FFFF_0F0F);
        @(negedge clk);
        chk("trig_regIn0", ri0, 8'h0F);
        chk("trig_regIn7", ri7, 8'h00);
        idle(1);
        wait_rsp(0);
        chk("trig_timeout_flag", got_timeout, 0);
        chk("trig_latency_le_9", (rsp_first_cyc - first_strobe_cyc + 1) <= 9, 1);
        chk("trig_strobes_done", exp_cmd_q.size(), 0);
        idle(2);

        // RD_SIZE returns 0x190
        plan(OP_RD_SIZE, 0, 1, 64'h0000_0000_0000_0190, 3'b100, 2);
        send_req(OP_RD_SIZE, 64'h0102_0304_0506_0708);
        wait_rsp(0);
        chk("rdsize_data", got_data, 64'h0000_0000_0000_0190);
        chk("rdsize_ack_bit", got_status[3], 1);
        chk("rdsize_strobes_done", exp_cmd_q.size(), 0);
        idle(2);

        // Stale ack present at request time
        ack_bit = 1;
        idle(2);
        plan(OP_RD_DATA, 1, 1, 64'hDEAD_BEEF_0000_0001, 3'b010, 2);
        send_req(OP_RD_DATA, 64'hCAFE_0000_0000_0055);
        wait_rsp(0);
        chk("stale_data", got_data, 64'hDEAD_BEEF_0000_0001);
        chk("stale_strobes_done", exp_cmd_q.size(), 0);
        idle(2);

        // RESET command, ack already high on WAITACK entry
        plan(OP_RESET, 0, 1, 64'h0909_0909_0909_0909, 3'b001, 1);
        send_req(OP_RESET, 64'h0);
        wait_rsp(0);
        chk("reset_cmd_status", got_status, 8'h09);
        chk("reset_cmd_strobes_done", exp_cmd_q.size(), 0);
        idle(2);

        // START never acknowledged -> timeout after TO_CYC cycles in WAITACK
        plan(OP_START, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011, 2);
        send_req(OP_START, 64'h0000_0000_0000_0001);
        wait_rsp(0);
        chk("timeout_flag", got_timeout, 1);
        chk("timeout_data", got_data, 64'h0);
        chk("timeout_latency", rsp_first_cyc - (first_strobe_cyc + 1), 16);
        idle(3);
        chk("timeout_strobes_done", exp_cmd_q.size(), 0);

        // NOP with 5 cycles of backpressure, next request held pending during RESP
        plan(OP_NOP, 0, 1, 64'h0, 3'b000, 2);
        send_req(OP_NOP, 64'h0123_4567_89AB_CDEF);
        host_if.req_valid   = 1'b1;
        host_if.req_opcode  = OP_ABORT;
        host_if.req_payload = 64'h5A5A_5A5A_0000_0002;
        wait_rsp(5);
        chk("nop_data", got_data, 64'h0);
        chk("nop_timeout_cleared", got_timeout, 0);
        chk("nop_valid_cycles", valid_run, 6);
        plan(OP_ABORT, 0, 1, 64'hA5A5_0000_1234_5678, 3'b000, 3);
        send_req(OP_ABORT, 64'h5A5A_5A5A_0000_0002);
        chk("b2b_accept_cycle", acc_cyc, hs_cyc + 1);
        wait_rsp(0);
        chk("abort_data", got_data, 64'hA5A5_0000_1234_5678);
        idle(2);

        // Reset while waiting for the ack to clear
        plan(OP_BUF_CFG, 0, 1, 64'h0000_0000_0000_0BCF, 3'b000, 2);
        never_clr = 1;
        send_req(OP_BUF_CFG, 64'h0000_0000_0000_4000);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exp_cmd_q.size() == 0) break;
        end
        chk("bufcfg_reached_clear", exp_cmd_q.size(), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset           = 1'b0;
        exp_payload     = '0;
        exp_rsp_allowed = 0;
        never_clr       = 0;
        ack_bit         = 0;
        ack_cnt         = 0;
        clr_cnt         = 0;
        @(negedge clk);
        chk("midrst_req_ready", host_if.req_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_command", command, 8'h00);
        chk("midrst_strobe", command_strobe, 0);
        chk("midrst_rsp_valid", host_if.rsp_valid, 0);
        idle(4);

        // Recovery after mid-operation reset
        plan(OP_RD_TRIG, 0, 1, 64'h7766_5544_3322_1100, 3'b101, 2);
        send_req(OP_RD_TRIG, 64'h8000_0000_0000_0010);
        wait_rsp(1);
        chk("rdtrig_data", got_data, 64'h7766_5544_3322_1100);
        chk("rdtrig_strobes_done", exp_cmd_q.size(), 0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logcap_cmd_initiator.md
Name: logcap_cmd_initiator

Overview:
- HUB-side initiator for the capture core's command/register interface.
- Accepts one host request at a time: opcode plus 64-bit payload.
  - Drives regIn0..7, pulses command/command_strobe, then waits for status acknowledge.
  - Captures regOut0..7, retires the acknowledge with CMD_ACK, and returns a response.
- Sits between the host transport decoder and the capture core.

Parameters:
- TIMEOUT_CYCLES, 4096, maximum cycles spent in any wait state before the request is abandoned.
- TO_W, 16, width of the timeout counter; TIMEOUT_CYCLES must be < 2^TO_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  host request valid
- req_ready  out  1  high only in IDLE
- req_opcode  in  8  command opcode
- req_payload  in  64  register payload; byte k goes to regIn k
- rsp_valid  out  1  response valid; held until rsp_ready
- rsp_ready  in  1  response accept
- rsp_data  out  64  {regOut7..regOut0} captured at acknowledge
- rsp_status  out  8  status sampled at acknowledge
- rsp_timeout  out  1  request abandoned on timeout
- regIn0..regIn7  out  8 each  command payload registers
- command  out  8  command code
- command_strobe  out  1  one-cycle command pulse
- status  in  8  bit3 = acknowledge, bit2 = postTrigger, bit1 = preTrigger, bit0 = idle
- regOut0..regOut7  in  8 each  response registers
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: all outputs 0, except req_ready = 1. command = 8'h00 (NOP). State IDLE. Timeout counter 0.
- All outputs are registered.
- States and transitions:
  - IDLE: on req_valid && req_ready, latch opcode and payload and drive regIn0..7 from the payload.
    - status[3] = 1 → PRECLR.
    - otherwise → ISSUE.
  - PRECLR: one-cycle strobe with command = 8'h08 (ACK) → PREWAIT.
  - PREWAIT: wait for status[3] = 0 → ISSUE.
  - ISSUE: command = latched opcode, command_strobe = 1 for exactly one cycle.
    - opcode 8'h00 (NOP) → RESP with rsp_data = 0; no acknowledge is expected.
    - any other opcode → WAITACK.
  - WAITACK: wait for status[3] = 1.
    - On that cycle, rsp_data = {regOut7..regOut0} and rsp_status = status.
    - regOut and acknowledge update on the same edge, so capturing in the same cycle is correct.
    - → CLEAR.
  - CLEAR: one-cycle strobe with command = 8'h08 → WAITCLR.
  - WAITCLR: wait for status[3] = 0 → RESP.
  - RESP: rsp_valid = 1; on rsp_ready → IDLE.
- command returns to 8'h00 on every cycle in which command_strobe = 0.
- regIn0..7 hold their values until the next accepted request, including while in RESP.
- Latency with no pre-clear, core acks 2 cycles after strobe: strobe in cycle 1 → rsp_valid asserted by cycle 9.
- Timeout behaviour:
  - The counter clears on entering each wait state (PREWAIT, WAITACK, WAITCLR) and increments each cycle spent in that state.
  - Expiry (count == TIMEOUT_CYCLES - 1 with condition unmet) → RESP with rsp_timeout = 1, rsp_data = 0, rsp_status = current status.
  - A timeout in WAITACK skips CLEAR.
  - rsp_timeout is cleared when the next request is accepted.
- Boundary conditions:
  - req_valid while busy: ignored (req_ready = 0); the request is not lost because the host holds valid.
  - status[3] already high in WAITACK entry cycle: accepted immediately. No stale-ack hazard, because PRECLR guarantees ack was low at ISSUE.
  - The 8'h09 (RESET) command clears core state; its acknowledge is handled identically.
  - Reset asserted mid-operation: immediate return to IDLE, strobe deasserted, no response emitted.
  - rsp_ready held high in RESP: single-cycle handshake; the next request may be accepted the following cycle.

Decomposition:
- Package logcap_cmd_pkg:
  - opcode localparams: NOP 00, START 01, ABORT 02, TRIG_CFG 03, BUF_CFG 04, RD_DATA 05, RD_SIZE 06, ACK 08, RESET 09, RD_TRIG 10;
  - status bit indices: ACK = 3, POST = 2, PRE = 1, IDLE = 0;
  - state encoding.
- Sub-module logcap_wait_timer: clear/enable inputs, expire output, parameterised by TIMEOUT_CYCLES/TO_W; shared by the three wait states.

Test Plan:
- TRIG_CFG: opcode 03, payload 0x0000_00FF_FFFF_0F0F; responder acks 2 cycles after strobe.
  → regIn0 = 0F, regIn7 = 00; exactly one strobe with command = 03, then one strobe with 08; rsp_valid with rsp_timeout = 0.
- RD_SIZE: responder sets regOut3..0 = 00_00_01_90 with ack.
  → rsp_data = 0x0000_0000_0000_0190; rsp_status[3] = 1.
- Stale ack: status[3] = 1 at request.
  → 08 is strobed first, then the opcode only after ack drops; the response is captured from the new ack.
- Timeout: TIMEOUT_CYCLES = 16, responder never acks opcode 01.
  → rsp_valid exactly 16 cycles after WAITACK entry; rsp_timeout = 1; no 08 strobe issued.
- NOP plus backpressure: opcode 00 with rsp_ready low for 5 cycles.
  → rsp_valid held 5+ cycles with stable data; req_ready = 0 throughout; a second request is accepted the cycle after the handshake.
- Reset at WAITCLR.
  → next cycle: IDLE, req_ready = 1, command = 00, strobe = 0, rsp_valid = 0.
